// File: rtl/y_drop_controller.sv
// Y-position sequencer for the falling block: spawns at the top, steps down on each frame
// tick, clamps onto the current landing row and tracks how many tower levels are filled.
module y_drop_controller #(
    parameter logic [6:0] Y_INIT     = 7'd104,
    parameter logic [6:0] Y_SPAWN    = 7'd0,
    parameter logic [6:0] UNIT_BLOCK = 7'd16,
    parameter logic [6:0] STEP       = 7'd2,
    parameter logic [2:0] LEVELS     = 3'd7
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       tick,
    input  logic       clear,
    output logic       y_parload,
    output logic [6:0] y_value,
    output logic       y_enable,
    output logic [2:0] level,
    output logic       busy,
    output logic       landed,
    output logic       tower_full
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPAWN = 3'd1,
        FALL  = 3'd2,
        LAND  = 3'd3,
        FULL  = 3'd4
    } state_t;

    state_t     state_r, state_nxt_s;
    logic [6:0] y_pos_r, y_pos_nxt_s;
    logic [2:0] level_r, level_nxt_s;
    logic       y_parload_r, y_parload_nxt_s;
    logic       y_enable_r, y_enable_nxt_s;
    logic       busy_r, busy_nxt_s;
    logic       landed_r, landed_nxt_s;
    logic       tower_full_r, tower_full_nxt_s;
    logic [6:0] target_s;
    logic [7:0] nxt_s;

    // Landing row shrinks by one block height per filled level; nxt keeps the carry for the clamp.
    assign target_s = Y_INIT - (UNIT_BLOCK * {4'd0, level_r});
    assign nxt_s    = {1'b0, y_pos_r} + {1'b0, STEP};

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= IDLE;
            y_pos_r      <= Y_INIT;
            level_r      <= 3'd0;
            y_parload_r  <= 1'b0;
            y_enable_r   <= 1'b0;
            busy_r       <= 1'b0;
            landed_r     <= 1'b0;
            tower_full_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            y_pos_r      <= y_pos_nxt_s;
            level_r      <= level_nxt_s;
            y_parload_r  <= y_parload_nxt_s;
            y_enable_r   <= y_enable_nxt_s;
            busy_r       <= busy_nxt_s;
            landed_r     <= landed_nxt_s;
            tower_full_r <= tower_full_nxt_s;
        end
    end

    // Next-state and next-output logic; clear overrides everything including start/tick.
    always_comb begin
        state_nxt_s      = state_r;
        y_pos_nxt_s      = y_pos_r;
        level_nxt_s      = level_r;
        y_parload_nxt_s  = 1'b0;
        y_enable_nxt_s   = y_enable_r;
        busy_nxt_s       = busy_r;
        landed_nxt_s     = 1'b0;
        tower_full_nxt_s = tower_full_r;
        if (clear) begin
            state_nxt_s      = IDLE;
            level_nxt_s      = 3'd0;
            tower_full_nxt_s = 1'b0;
            y_pos_nxt_s      = Y_INIT;
            y_parload_nxt_s  = 1'b1;
            busy_nxt_s       = 1'b0;
            y_enable_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !tower_full_r) begin
                        state_nxt_s = SPAWN;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                SPAWN: begin
                    y_pos_nxt_s     = Y_SPAWN;
                    y_parload_nxt_s = 1'b1;
                    busy_nxt_s      = 1'b1;
                    y_enable_nxt_s  = 1'b1;
                    state_nxt_s     = FALL;
                end
                FALL: begin
                    if (tick) begin
                        y_parload_nxt_s = 1'b1;
                        if (nxt_s >= {1'b0, target_s}) begin
                            y_pos_nxt_s = target_s;
                            state_nxt_s = LAND;
                        end else begin
                            y_pos_nxt_s = nxt_s[6:0];
                            state_nxt_s = FALL;
                        end
                    end else begin
                        state_nxt_s = FALL;
                    end
                end
                LAND: begin
                    landed_nxt_s   = 1'b1;
                    level_nxt_s    = level_r + 3'd1;
                    busy_nxt_s     = 1'b0;
                    y_enable_nxt_s = 1'b0;
                    if ((level_r + 3'd1) == LEVELS) begin
                        tower_full_nxt_s = 1'b1;
                        state_nxt_s      = FULL;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                FULL: begin
                    state_nxt_s = FULL;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    assign y_parload  = y_parload_r;
    assign y_value    = y_pos_r;
    assign y_enable   = y_enable_r;
    assign level      = level_r;
    assign busy       = busy_r;
    assign landed     = landed_r;
    assign tower_full = tower_full_r;

endmodule

// File: tb/tb_y_drop_controller.sv
// Scoreboard bench: expected load/landing events are queued at stimulus time and popped by
// per-instance monitors whenever the controller strobes y_parload or landed.
module tb_y_drop_controller;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       start = 1'b0, tick = 1'b0, clear = 1'b0;
    logic       start3 = 1'b0, tick3 = 1'b0, clear3 = 1'b0;
    logic       y_parload, y_enable, busy, landed, tower_full;
    logic [6:0] y_value;
    logic [2:0] level;
    logic       y_parload3, y_enable3, busy3, landed3, tower_full3;
    logic [6:0] y_value3;
    logic [2:0] level3;

    int n_cmp = 0;
    int n_bad = 0;
    int landed_cnt = 0;
    logic [14:0] q2[$];
    logic [14:0] q3[$];

    // Hand-computed landing rows and tick counts (STEP=2) for levels 0..6.
    logic [6:0] tgt[7]    = '{7'd104, 7'd88, 7'd72, 7'd56, 7'd40, 7'd24, 7'd8};
    int         nticks[7] = '{52, 44, 36, 28, 20, 12, 4};

    always #5 clk = ~clk;

    y_drop_controller #(.STEP(7'd2)) u_dut (
        .clk(clk), .resetn(resetn), .start(start), .tick(tick), .clear(clear),
        .y_parload(y_parload), .y_value(y_value), .y_enable(y_enable), .level(level),
        .busy(busy), .landed(landed), .tower_full(tower_full)
    );

    y_drop_controller #(.STEP(7'd3)) u_dut3 (
        .clk(clk), .resetn(resetn), .start(start3), .tick(tick3), .clear(clear3),
        .y_parload(y_parload3), .y_value(y_value3), .y_enable(y_enable3), .level(level3),
        .busy(busy3), .landed(landed3), .tower_full(tower_full3)
    );

    function automatic logic [14:0] rec(input logic pl, input logic ld, input logic en,
                                        input logic bz, input logic tf,
                                        input logic [2:0] lv, input logic [6:0] y);
        return {pl, ld, en, bz, tf, lv, y};
    endfunction

    always @(negedge clk) begin
        logic [14:0] act, req;
        if (resetn && (y_parload || landed)) begin
            act = rec(y_parload, landed, y_enable, busy, tower_full, level, y_value);
            n_cmp++;
            if (landed) landed_cnt++;
            if (q2.size() == 0) begin
                n_bad++;
                $display("FAIL event2 unexpected act=%h req=none t=%0t", act, $time);
            end else begin
                req = q2.pop_front();
                if (act !== req) begin
                    n_bad++;
                    $display("FAIL event2 act=%h req=%h t=%0t", act, req, $time);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [14:0] act, req;
        if (resetn && (y_parload3 || landed3)) begin
            act = rec(y_parload3, landed3, y_enable3, busy3, tower_full3, level3, y_value3);
            n_cmp++;
            if (q3.size() == 0) begin
                n_bad++;
                $display("FAIL event3 unexpected act=%h req=none t=%0t", act, $time);
            end else begin
                req = q3.pop_front();
                if (act !== req) begin
                    n_bad++;
                    $display("FAIL event3 act=%h req=%h t=%0t", act, req, $time);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_y"}, {25'd0, y_value}, 32'd104);
        check({nm, "_level"}, {29'd0, level}, 32'd0);
        check({nm, "_flags"}, {26'd0, y_parload, y_enable, busy, landed, tower_full, 1'b0}, 32'd0);
    endtask

    // One complete drop at level lv on the STEP=2 instance.
    task automatic drop(input int lv, input logic with_tick, input logic extra);
        int n;
        n = nticks[lv];
        q2.push_back(rec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, lv[2:0], 7'd0));
        start = 1'b1; tick = with_tick; cyc();
        start = 1'b0; tick = extra; cyc();
        tick = 1'b0;
        for (int k = 1; k <= n; k++) begin
            tick = 1'b1;
            q2.push_back(rec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, lv[2:0],
                             (k == n) ? tgt[lv] : 7'(2 * k)));
            cyc();
            tick = 1'b0;
            if (k < n) cyc();
        end
        q2.push_back(rec(1'b0, 1'b1, 1'b0, 1'b0, (lv == 6), 3'(lv + 1), tgt[lv]));
        tick = extra; cyc();
        tick = extra; cyc();
        tick = 1'b0; cyc();
    endtask

    initial begin
        #2 resetn = 1'b0;
        #2 check_reset_outputs("reset");
        cyc(); cyc();
        resetn = 1'b1;
        cyc();

        // Reset asserted mid-fall returns outputs before the next clock edge.
        q2.push_back(rec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 7'd0));
        start = 1'b1; cyc(); start = 1'b0; cyc();
        for (int k = 1; k <= 5; k++) begin
            tick = 1'b1;
            q2.push_back(rec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 7'(2 * k)));
            cyc(); tick = 1'b0; cyc();
        end
        resetn = 1'b0;
        #2 check_reset_outputs("async_rst");
        cyc();
        resetn = 1'b1;
        cyc();

        // Seven drops: first uses start+tick together, all inject dropped ticks.
        drop(0, 1'b1, 1'b1);
        for (int lv = 1; lv < 7; lv++) drop(lv, 1'b0, 1'b1);
        check("full_level", {29'd0, level}, 32'd7);
        check("full_flag", {31'd0, tower_full}, 32'd1);

        // Start while full is ignored.
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("full_busy", {31'd0, busy}, 32'd0);
            check("full_parload", {31'd0, y_parload}, 32'd0);
            cyc();
        end

        q2.push_back(rec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 7'd104));
        clear = 1'b1; cyc(); clear = 1'b0; cyc();
        check("clr_full_level", {29'd0, level}, 32'd0);
        check("clr_full_flag", {31'd0, tower_full}, 32'd0);

        drop(0, 1'b0, 1'b0);
        drop(1, 1'b0, 1'b0);
        drop(2, 1'b0, 1'b0);

        // Clear mid-fall at level 3, y=30, with start and tick also high.
        q2.push_back(rec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 7'd0));
        start = 1'b1; cyc(); start = 1'b0; cyc();
        for (int k = 1; k <= 15; k++) begin
            tick = 1'b1;
            q2.push_back(rec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 7'(2 * k)));
            cyc(); tick = 1'b0; cyc();
        end
        check("pre_clear_y", {25'd0, y_value}, 32'd30);
        q2.push_back(rec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 7'd104));
        clear = 1'b1; start = 1'b1; tick = 1'b1; cyc();
        clear = 1'b0; start = 1'b0; tick = 1'b0;
        cyc();
        check("post_clear_parload", {31'd0, y_parload}, 32'd0);
        check("post_clear_busy", {31'd0, busy}, 32'd0);
        check("post_clear_y", {25'd0, y_value}, 32'd104);
        for (int i = 0; i < 4; i++) cyc();
        check("post_clear_idle_busy", {31'd0, busy}, 32'd0);
        check("landed_count", landed_cnt, 32'd10);

        // STEP=3 instance: 34 ticks reach 102, the 35th clamps to 104.
        q3.push_back(rec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 7'd0));
        start3 = 1'b1; cyc(); start3 = 1'b0; cyc();
        for (int k = 1; k <= 35; k++) begin
            tick3 = 1'b1;
            q3.push_back(rec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0,
                             (k == 35) ? 7'd104 : 7'(3 * k)));
            cyc(); tick3 = 1'b0; cyc();
        end
        q3.push_back(rec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 7'd104));
        cyc(); cyc();
        check("step3_level", {29'd0, level3}, 32'd1);

        check("q2_drained", q2.size(), 32'd0);
        check("q3_drained", q3.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
